// File: rtl/wave_freq_decoder_if.sv
// wave_freq_decoder_if: the incoming wave and the decoded frequency-code outputs.
// The slave side is the decoder. The master side drives the wave and observes the code.
interface wave_freq_decoder_if;
    logic       wave;
    logic [3:0] freqValue;
    logic       freq_valid;
    logic       freq_change;
    logic       no_signal;

    modport master (output wave, input freqValue, freq_valid, freq_change, no_signal);
    modport slave  (input wave, output freqValue, freq_valid, freq_change, no_signal);
endinterface

// File: rtl/wave_freq_decoder.sv
// wave_freq_decoder: recovers the 4-bit frequency code of a square wave by
// measuring its rising-edge-to-rising-edge period in clk cycles.
// Optional macro WAVE_GLITCH_FILTER_EN adds a 3-sample glitch filter after
// the synchronizer. The filter adds 2 clk of edge latency and rejects pulses of 1-2 clk.
//
// state   | meaning
// IDLE    | no reference edge yet (after reset or timeout)
// MEASURE | collecting consecutive matching periods
// LOCKED  | code published, freq_valid high
module wave_freq_decoder #(
    parameter int BASE_HALF_PERIOD = 4,
    parameter int TOL              = 1,
    parameter int LOCK_COUNT       = 2,
    parameter int CNT_W            = 12
) (
    input logic                clk,
    input logic                reset,
    wave_freq_decoder_if.slave bus
);
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(2*BASE_HALF_PERIOD*16 + 4*BASE_HALF_PERIOD);
    localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;
    state_t state, state_nx;

    logic             sync1, sync2, rise, timeout;
    logic [CNT_W-1:0] cnt;
    logic             hit;
    logic [3:0]       code;
    logic [3:0]       cand, cand_d, mcnt, mcnt_d, mcnt_up, freq_code, code_d;
    logic             valid, valid_d, change, change_d, nosig, nosig_d, published, pub_d;
    logic             lock_now;

    // Two-flop synchronizer for the asynchronous wave input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.wave;
            sync2 <= sync1;
        end
    end

`ifdef WAVE_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       filt_q, filt_d;

    // Keep the last two synced samples and the filtered level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist   <= 2'b00;
            filt_q <= 1'b0;
        end else begin
            hist   <= {hist[0], sync2};
            filt_q <= filt_d;
        end
    end

    // Filtered level follows the input only after three equal samples
    always_comb begin
        filt_d = filt_q;
        if (sync2 == hist[0] && sync2 == hist[1]) filt_d = sync2;
    end

    assign rise = filt_d & ~filt_q;
`else
    logic sync_prev;

    // Previous synced level for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_prev <= 1'b0;
        else       sync_prev <= sync2;
    end

    assign rise = sync2 & ~sync_prev;
`endif

    // Period counter: restarts at 1 on each edge and saturates at the timeout
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                cnt <= '0;
        else if (rise)            cnt <= CNT_W'(1);
        else if (cnt < TIMEOUT)   cnt <= cnt + CNT_W'(1);
    end

    // A rising edge in the same cycle takes priority over the timeout
    assign timeout = !rise && (cnt == TIMEOUT);

    // Classify the measured period; iterate downwards so the lowest code wins
    always_comb begin
        logic [CNT_W-1:0] p, diff;
        hit  = 1'b0;
        code = 4'd0;
        p    = '0;
        diff = '0;
        for (int c = 15; c >= 0; c--) begin
            p    = CNT_W'(2*BASE_HALF_PERIOD*(c+1));
            diff = (cnt >= p) ? cnt - p : p - cnt;
            if (diff <= CNT_W'(TOL)) begin
                hit  = 1'b1;
                code = 4'(c);
            end
        end
    end

    assign mcnt_up  = (code == cand) ? mcnt + 4'd1 : 4'd1;
    assign lock_now = hit && (mcnt_up == LOCK_N);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        if (rise) begin
            case (state)
                IDLE:    state_nx = MEASURE;
                MEASURE: if (lock_now) state_nx = LOCKED;
                LOCKED:  if (!(hit && code == freq_code)) state_nx = MEASURE;
                default: state_nx = IDLE;
            endcase
        end else if (timeout) begin
            state_nx = IDLE;
        end
    end

    // Next values of the match tracker and the published outputs
    always_comb begin
        cand_d   = cand;
        mcnt_d   = mcnt;
        code_d   = freq_code;
        valid_d  = valid;
        change_d = 1'b0;
        nosig_d  = nosig;
        pub_d    = published;
        if (rise) begin
            nosig_d = 1'b0;
            case (state)
                IDLE: mcnt_d = 4'd0;
                MEASURE: begin
                    if (hit) begin
                        cand_d = code;
                        mcnt_d = mcnt_up;
                    end else begin
                        mcnt_d = 4'd0;
                    end
                    if (lock_now) begin
                        code_d   = code;
                        valid_d  = 1'b1;
                        change_d = !published || (code != freq_code);
                        pub_d    = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!(hit && code == freq_code)) begin
                        valid_d = 1'b0;
                        if (hit) begin
                            cand_d = code;
                            mcnt_d = 4'd1;
                        end else begin
                            mcnt_d = 4'd0;
                        end
                    end
                end
                default: mcnt_d = 4'd0;
            endcase
        end else if (timeout) begin
            nosig_d = 1'b1;
            valid_d = 1'b0;
            mcnt_d  = 4'd0;
            pub_d   = 1'b0;
        end
    end

    // Register tracker state and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand      <= 4'd0;
            mcnt      <= 4'd0;
            freq_code <= 4'd0;
            valid     <= 1'b0;
            change    <= 1'b0;
            nosig     <= 1'b0;
            published <= 1'b0;
        end else begin
            cand      <= cand_d;
            mcnt      <= mcnt_d;
            freq_code <= code_d;
            valid     <= valid_d;
            change    <= change_d;
            nosig     <= nosig_d;
            published <= pub_d;
        end
    end

    assign bus.freqValue   = freq_code;
    assign bus.freq_valid  = valid;
    assign bus.freq_change = change;
    assign bus.no_signal   = nosig;
endmodule

// File: tb/tb_wave_freq_decoder.sv
// tb_wave_freq_decoder: drives square waves of chosen periods, predicts the
// decoder outputs with a period-level model and compares through a scoreboard.
module tb_wave_freq_decoder;
    localparam int BHP     = 4;
    localparam int TOL     = 1;
    localparam int LOCKN   = 2;
    localparam int TIMEOUT = 144;
`ifdef WAVE_GLITCH_FILTER_EN
    localparam int LAT         = 5;
    localparam bit GLITCH_SEEN = 1'b0;
`else
    localparam int LAT         = 3;
    localparam bit GLITCH_SEEN = 1'b1;
`endif
    localparam int S_IDLE = 0, S_MEAS = 1, S_LOCK = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;

    wave_freq_decoder_if bus();

    wave_freq_decoder #(.BASE_HALF_PERIOD(BHP), .TOL(TOL), .LOCK_COUNT(LOCKN), .CNT_W(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    due;
        string tag;
        int    code;
        int    valid;
        int    chg;
        int    nosig;
    } exp_t;
    exp_t q[$];

    int m_state, m_cand, m_mcnt, m_code, m_valid, m_chg, m_nosig, m_pub, m_last, nrise;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic model_init();
        m_state = S_IDLE; m_cand = 0; m_mcnt = 0; m_code = 0;
        m_valid = 0; m_chg = 0; m_nosig = 0; m_pub = 0; m_last = 0;
    endtask

    task automatic push(input int due, input string tag);
        exp_t e;
        e.due = due; e.tag = tag; e.code = m_code; e.valid = m_valid;
        e.chg = m_chg; e.nosig = m_nosig;
        q.push_back(e);
    endtask

    task automatic model_rise(input int n);
        int gap, c, d;
        bit hit;
        gap = n - m_last;
        m_last = n;
        m_chg = 0;
        nrise++;
        if (m_state != S_IDLE && gap > TIMEOUT) begin
            m_state = S_IDLE; m_valid = 0; m_pub = 0;
        end
        m_nosig = 0;
        if (m_state == S_IDLE) begin
            m_state = S_MEAS;
            m_mcnt = 0;
        end else begin
            c = (gap + BHP) / (2*BHP) - 1;
            d = gap - 2*BHP*(c+1);
            if (d < 0) d = -d;
            hit = (c >= 0) && (c <= 15) && (d <= TOL);
            if (m_state == S_LOCK) begin
                if (!(hit && c == m_code)) begin
                    m_state = S_MEAS;
                    m_valid = 0;
                    if (hit) begin m_cand = c; m_mcnt = 1; end
                    else m_mcnt = 0;
                end
            end else begin
                if (hit && c == m_cand) m_mcnt++;
                else if (hit) begin m_cand = c; m_mcnt = 1; end
                else m_mcnt = 0;
                if (hit && m_mcnt == LOCKN) begin
                    m_state = S_LOCK;
                    m_chg = (!m_pub || c != m_code) ? 1 : 0;
                    m_code = c; m_valid = 1; m_pub = 1;
                end
            end
        end
        push(n + LAT, $sformatf("rise%0d", nrise));
        m_chg = 0;
        push(n + LAT + 1, $sformatf("rise%0d_next", nrise));
    endtask

    task automatic pulse(input int period, input bit glitch);
        @(negedge clk);
        bus.wave = 1'b1;
        model_rise(cyc);
        for (int k = 1; k < period; k++) begin
            @(negedge clk);
            if (k == period/2) bus.wave = 1'b0;
            if (glitch && k == period/2 + 3) begin
                bus.wave = 1'b1;
                if (GLITCH_SEEN) model_rise(cyc);
            end
            if (glitch && k == period/2 + 4) bus.wave = 1'b0;
        end
    endtask

    // One last rise, then the wave stays low long enough to time out.
    task automatic hold_low(input int high_len);
        int e;
        @(negedge clk);
        bus.wave = 1'b1;
        model_rise(cyc);
        e = cyc + LAT;
        m_chg = 0;
        push(e + TIMEOUT - 1, "pre_timeout");
        m_nosig = 1; m_valid = 0; m_state = S_IDLE; m_pub = 0; m_mcnt = 0;
        push(e + TIMEOUT, "timeout");
        for (int k = 1; k < TIMEOUT + 20; k++) begin
            @(negedge clk);
            if (k == high_len) bus.wave = 1'b0;
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk({tag, "_code"},   int'(bus.freqValue),   0);
        chk({tag, "_valid"},  int'(bus.freq_valid),  0);
        chk({tag, "_change"}, int'(bus.freq_change), 0);
        chk({tag, "_nosig"},  int'(bus.no_signal),   0);
        q.delete();
        model_init();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    // Scoreboard: pop and compare entries as their due cycle arrives
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                if (e.due < cyc) begin
                    chk({e.tag, "_late"}, cyc, e.due);
                end else begin
                    chk({e.tag, "_code"},   int'(bus.freqValue),   e.code);
                    chk({e.tag, "_valid"},  int'(bus.freq_valid),  e.valid);
                    chk({e.tag, "_change"}, int'(bus.freq_change), e.chg);
                    chk({e.tag, "_nosig"},  int'(bus.no_signal),   e.nosig);
                end
            end
        end
    end

    initial begin
        int waited;
        bus.wave = 1'b0;
        nrise = 0;
        model_init();
        #1;
        chk("reset_code",   int'(bus.freqValue),   0);
        chk("reset_valid",  int'(bus.freq_valid),  0);
        chk("reset_change", int'(bus.freq_change), 0);
        chk("reset_nosig",  int'(bus.no_signal),   0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        repeat (5) pulse(8, 1'b0);
        repeat (4) pulse(16, 1'b0);
        repeat (4) pulse(24, 1'b0);
        pulse(23, 1'b0); pulse(25, 1'b0); pulse(23, 1'b0); pulse(25, 1'b0);
        pulse(24, 1'b0); pulse(21, 1'b0);
        repeat (3) pulse(24, 1'b0);

        repeat (4) pulse(16, 1'b0);
        pulse(16, 1'b1);
        repeat (3) pulse(16, 1'b0);

        repeat (4) pulse(24, 1'b0);
        hold_low(12);
        repeat (4) pulse(24, 1'b0);

        do_reset("rst_locked");
        repeat (2) pulse(8, 1'b0);
        do_reset("rst_measure");
        repeat (4) pulse(16, 1'b0);

        waited = 0;
        while (q.size() > 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() > 0) chk("drain_queue", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/wave_freq_decoder.md
Name: wave_freq_decoder

Overview:
- Receive-side counterpart of the wave signal generator: takes the square `wave` it produces and recovers the 4-bit `freqValue` code that set its frequency.
- Measures the rising-edge-to-rising-edge period in `clk` cycles and matches it against the generator's period table within a tolerance.
- Publishes the code once a configurable number of consecutive matching periods is seen.
- Sits on the loopback/monitor path next to the generator; used for self-check and for decoding externally supplied waves.

Parameters:
- BASE_HALF_PERIOD, 4: half-period of code 0, in clk cycles. Expected full period for code c is P(c) = 2*BASE_HALF_PERIOD*(c+1).
- TOL, 1: accepted |measured - P(c)| in clk cycles, inclusive. Must be < BASE_HALF_PERIOD so the windows do not overlap.
- LOCK_COUNT, 2: consecutive matching periods of the same code required to lock (1..15).
- CNT_W, 12: period counter width. Must hold P(15) + BASE_HALF_PERIOD*4.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- wave, input, 1: square wave from the generator, asynchronous to clk.
- freqValue, output, 4: decoded frequency code.
- freq_valid, output, 1: high while locked; `freqValue` is meaningful only then.
- freq_change, output, 1: one-cycle pulse when `freqValue` takes a new value while locked, or on first lock.
- no_signal, output, 1: high when no rising edge has been seen for the timeout window.

Behaviour:
- Reset values: `freqValue`=0, `freq_valid`=0, `freq_change`=0, `no_signal`=0. Counters are 0, FSM is IDLE, synchronizer is 0.
- Reset takes effect mid-measurement immediately; the next lock requires a fresh first edge.
- Input path: 2-FF synchronizer. A rising edge is detected when the synced value is 1 and its previous value is 0. Wave-to-edge latency is 3 clk.
- Period counter:
  - Cleared to 1 on each detected edge, increments otherwise.
  - Saturates at TIMEOUT = P(15) + 4*BASE_HALF_PERIOD.
- FSM states and transitions:
  - IDLE: wait for the first edge, then go to MEASURE. Matching-count = 0.
  - MEASURE, on each edge: classify the period as the code c with |cnt - P(c)| <= TOL, else "no match".
    - Match equal to the previous candidate: increment matching-count.
    - Match to a different code: candidate = c, matching-count = 1.
    - No match: matching-count = 0.
    - Matching-count reaches LOCK_COUNT: go to LOCKED. The cycle after the completing edge, load `freqValue`, set `freq_valid`, pulse `freq_change`.
  - LOCKED, on each edge:
    - Matches current `freqValue`: stay.
    - Matches a different code: go to MEASURE with that candidate and matching-count = 1. `freq_valid` drops the cycle after the edge; `freqValue` holds its old value.
    - No match: go to MEASURE with matching-count = 0; `freq_valid` drops.
  - `freq_change` pulses on every transition into LOCKED where the new code differs from the last published code, and always on the first lock after reset/no_signal.
- Timeout:
  - Counter reaches TIMEOUT from any state: `no_signal`=1, `freq_valid`=0, FSM goes to IDLE. `freqValue` holds.
  - `no_signal` clears on the next detected edge.
- Edge in the same cycle as the timeout: the edge wins; no timeout.
- Period arithmetic is unsigned CNT_W bits. Classification is a combinational compare over all 16 codes; the lowest matching c wins (windows are disjoint by parameter rule).

Optional Feature:
- Macro: WAVE_GLITCH_FILTER_EN.
- When defined: after the synchronizer, the filtered wave changes only after 3 consecutive equal samples. Edge latency becomes 5 clk; measured periods are unchanged for clean input. Pulses of 1-2 cycles are ignored.
- When undefined: no filter; every synced transition counts.

Test Plan:
(All scenarios use BASE_HALF_PERIOD=4, TOL=1, LOCK_COUNT=2.)
- Wave with period 8 clk after reset release -> `freq_valid`=1 and `freqValue`=0 the cycle after the 3rd rising edge (2 full matched periods); `freq_change` pulses once.
- Switch wave to period 16 then 24 (codes 1, 2) -> `freq_valid` drops after the first changed period, relocks after 2 periods with `freqValue`=1, then 2; one `freq_change` pulse each.
- Period jitter alternating 23/25 -> stays locked on code 2. Period 21 -> no match, `freq_valid`=0 after that edge.
- Wave held low after lock -> `no_signal`=1 exactly TIMEOUT (144) cycles after the last edge; `freq_valid`=0, `freqValue` retains 2. Next edge clears `no_signal`.
- Assert reset mid-measurement and while locked -> all outputs 0 asynchronously. Relock needs a fresh first edge + LOCK_COUNT periods.
- With WAVE_GLITCH_FILTER_EN: 1-cycle high glitch inside a 16-cycle period -> lock on code 1 is kept. Without the macro, the same stimulus -> `freq_valid` drops.
